sobel_window_ctrl: RTL and testbench
====================================

// Module: sobel_window_ctrl
// PURPOSE
//  Raster-scan sequencer for the 3x3 Sobel edge datapath. Accepts one 8-bit pixel per beat.
//  Holds two line buffers and a 3x3 shift window, and presents p00..p22 to the edge core.
//  Emits exactly IMG_W*IMG_H window results per frame; flushes the tail with injected zeros.
//  Tags frame-border centres so downstream forces them to black; pulses frame_done at the end.
// PARAMETERS
//  IMG_W     640  pixels per line (>=3)
//  IMG_H     480  lines per frame (>=3)
//  EDGE_LAT  1    pipeline latency of the edge core, in cycles (>=1)
// PORTS
//  clk         in   1   single clock; all logic on rising edge
//  rst         in   1   synchronous, active-high reset
//  start       in   1   begin a frame; ignored unless state==IDLE
//  s_pix       in   8   input pixel, raster order
//  s_valid     in   1   s_pix valid
//  s_ready     out  1   controller accepts s_pix this cycle
//  win         out  72  {p00,p01,p02,p10,p11,p12,p20,p21,p22}; p00 in [71:64]
//  win_valid   out  1   win holds a new centre this cycle
//  win_border  out  1   win centre lies on row 0, row IMG_H-1, col 0 or col IMG_W-1
//  edge_valid  out  1   win_valid delayed by EDGE_LAT; qualifies the edge core output
//  edge_border out  1   win_border delayed by EDGE_LAT; downstream forces edge_out to 0 when set
//  frame_done  out  1   one-cycle pulse together with the last edge_valid of a frame
//  busy        out  1   state != IDLE
// BEHAVIOUR
//  Reset values: all outputs 0, state IDLE, all counters 0. Line-buffer RAM is not cleared.
//  rst mid-frame: state returns to IDLE on the next edge; delay pipes are cleared; no frame_done pulse.
//  States and transitions:
//   - IDLE -> FILL on start.
//   - FILL -> RUN after in_cnt == IMG_W+1 accepted beats.
//   - RUN -> FLUSH after in_cnt == IMG_W*IMG_H.
//   - FLUSH -> DRAIN after IMG_W+1 flush beats.
//   - DRAIN -> IDLE when frame_done fires.
//  s_ready = 1 in FILL and RUN, else 0. Accept = s_valid & s_ready; no beat is lost or duplicated.
//  Beat: an accept (FILL/RUN) or each FLUSH cycle. In FLUSH the beat pixel is 8'd0.
//  On each beat, with col c (0..IMG_W-1):
//   - Read LB0[c] and LB1[c]; write LB0[c]<=LB1[c] and LB1[c]<=pix (read-before-write).
//   - Window columns shift left.
//   - New right column: p02=old LB0[c], p12=old LB1[c], p22=pix.
//  col wraps IMG_W-1 -> 0 and increments row. Counters are 16 bit and saturate-free within one frame.
//  win_valid is registered: high in the cycle after a beat whose beat index k >= IMG_W+1.
//  Beat index k counts accepts plus flush beats, starting at 0.
//  Centre of that window is index k-(IMG_W+1): row=(k-W-1)/W, col=(k-W-1)%W, tracked by separate counters.
//  win_border is computed from the centre counters, registered with win_valid.
//  At centre col 0 or col W-1 the window wraps across lines; such windows are tagged border, contents don't-care.
//  No beat in a cycle (s_valid=0 in FILL/RUN) -> win_valid=0, win holds its value.
//  win_valid total per frame = IMG_W*IMG_H; the last one comes from the final FLUSH beat.
//  edge_valid/edge_border: EDGE_LAT-deep shift of win_valid/win_border.
//  frame_done = edge_valid & (edge_valid count == IMG_W*IMG_H).
//  Edge-count counter clears in IDLE.
//  start asserted in the same cycle as frame_done: ignored (state is still DRAIN).
//  Input latency: pixel accepted at cycle t -> its edge result qualified at t+1+EDGE_LAT+...
//   ...after W+1 further beats.
// TESTING (IMG_W=4, IMG_H=3, EDGE_LAT=1 unless noted)
//  1. rst, start, s_valid=1 with pixels 1..12 back-to-back:
//     s_ready high exactly 12 cycles; 5 flush cycles follow.
//     win_valid count=12; first window centre=pixel 1; frame_done once, with the 12th edge_valid.
//  2. Centre (row1,col1) with pixels 1..12:
//     win = {1,2,3,5,6,7,9,10,11}, win_border=0.
//     Only centres (1,1) and (1,2) have border=0.
//  3. s_valid toggled 1/0 every cycle:
//     same 12 windows and the same contents as test 1; win_valid never high in a cycle following no beat.
//  4. rst asserted mid-RUN after 7 accepts:
//     next cycle busy=0, s_ready=0, edge_valid=0, no frame_done.
//     A new start plus 12 pixels reproduces test 1.
//  5. start pulsed while busy:
//     no effect.
//     Start in the same cycle as frame_done: ignored; busy=0 the next cycle.
//  6. Two frames back-to-back (start the cycle after busy falls), EDGE_LAT=3:
//     edge_valid lags win_valid by exactly 3 cycles.
//     24 edge_valid total, 2 frame_done pulses.

Source files
------------

// File: rtl/sobel_window_ctrl.sv
// Raster-scan sequencer for a 3x3 Sobel edge core.
// Streams pixels through two line buffers into a 3x3 shift window, flushes the
// frame tail with zero pixels, tags border centres and delays the window
// qualifiers by the edge-core latency.
//
// Handshake: a pixel is transferred on a rising edge where s_valid and s_ready
// are both high; s_ready depends only on the state register, never on s_valid.
module sobel_window_ctrl #(
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int EDGE_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  s_pix,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [71:0] win,
    output logic        win_valid,
    output logic        win_border,
    output logic        edge_valid,
    output logic        edge_border,
    output logic        frame_done,
    output logic        busy
);

    localparam int TOTAL = IMG_W * IMG_H;          // windows per frame
    localparam int BEATS = TOTAL + IMG_W + 1;      // accepts plus flush beats
    localparam int KW    = $clog2(BEATS + 1);
    localparam int EW    = $clog2(TOTAL + 1);
    localparam int AW    = $clog2(IMG_W);

    localparam logic [KW-1:0] K_FILL   = KW'(IMG_W + 1);
    localparam logic [KW-1:0] K_RUN    = KW'(TOTAL);
    localparam logic [KW-1:0] K_END    = KW'(BEATS);
    localparam logic [15:0]   COL_LAST = 16'(IMG_W - 1);
    localparam logic [15:0]   ROW_LAST = 16'(IMG_H - 1);
    localparam logic [EW-1:0] E_TOTAL  = EW'(TOTAL);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN,
        ST_FLUSH,
        ST_DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q;          // beat index within the frame
    logic [KW-1:0]   k_inc;
    logic [15:0]     col_q;        // input column, addresses the line buffers
    logic [15:0]     cc_q, cr_q;   // centre column / row of the next window
    logic [71:0]     win_q;
    logic            wv_q, wb_q;
    logic            beat, emit, centre_border;
    logic [7:0]      pix;
    logic [7:0]      lb0_rd, lb1_rd;
    logic [7:0]      lb0_q [IMG_W];
    logic [7:0]      lb1_q [IMG_W];

    logic [EDGE_LAT-1:0] ev_pipe_q, eb_pipe_q;
    logic [EDGE_LAT:0]   ev_chain, eb_chain;
    logic                ev_in;
    logic [EW-1:0]       edge_cnt_q;
    logic                fd_q;

    // Beat qualification, flush pixel injection and line-buffer read ports
    always_comb begin
        s_ready       = (state_q == ST_FILL) || (state_q == ST_RUN);
        beat          = (s_valid && s_ready) || (state_q == ST_FLUSH);
        pix           = (state_q == ST_FLUSH) ? 8'd0 : s_pix;
        k_inc         = k_q + KW'(1);
        emit          = beat && (k_q >= K_FILL);
        lb0_rd        = lb0_q[col_q[AW-1:0]];
        lb1_rd        = lb1_q[col_q[AW-1:0]];
        centre_border = (cr_q == 16'd0) || (cr_q == ROW_LAST) ||
                        (cc_q == 16'd0) || (cc_q == COL_LAST);
    end

    // Frame sequencer next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_FILL;
            ST_FILL:  if (beat && (k_inc == K_FILL)) state_d = ST_RUN;
            ST_RUN:   if (beat && (k_inc == K_RUN)) state_d = ST_FLUSH;
            ST_FLUSH: if (k_inc == K_END) state_d = ST_DRAIN;
            ST_DRAIN: if (fd_q) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Frame sequencer state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Beat counters, 3x3 shift window and registered window qualifiers
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q   <= '0;
            col_q <= '0;
            cc_q  <= '0;
            cr_q  <= '0;
            win_q <= '0;
            wv_q  <= 1'b0;
            wb_q  <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            k_q   <= '0;
            col_q <= '0;
            cc_q  <= '0;
            cr_q  <= '0;
            wv_q  <= 1'b0;
            wb_q  <= 1'b0;
        end else begin
            wv_q <= emit;
            wb_q <= emit && centre_border;
            if (beat) begin
                // columns shift left; new right column is LB0, LB1, live pixel
                win_q <= {win_q[63:48], lb0_rd, win_q[39:24], lb1_rd, win_q[15:0], pix};
                k_q   <= k_inc;
                col_q <= (col_q == COL_LAST) ? 16'd0 : col_q + 16'd1;
            end
            if (emit) begin
                if (cc_q == COL_LAST) begin
                    cc_q <= 16'd0;
                    cr_q <= cr_q + 16'd1;
                end else begin
                    cc_q <= cc_q + 16'd1;
                end
            end
        end
    end

    // Line buffers: LB0 takes the row LB1 held, LB1 takes the new pixel
    always_ff @(posedge clk) begin
        if (beat) begin
            lb0_q[col_q[AW-1:0]] <= lb1_rd;
            lb1_q[col_q[AW-1:0]] <= pix;
        end
    end

    assign ev_chain = {ev_pipe_q, wv_q};
    assign eb_chain = {eb_pipe_q, wb_q};
    assign ev_in    = ev_chain[EDGE_LAT-1];

    // Edge-core latency match and end-of-frame detection
    always_ff @(posedge clk) begin
        if (rst) begin
            ev_pipe_q  <= '0;
            eb_pipe_q  <= '0;
            edge_cnt_q <= '0;
            fd_q       <= 1'b0;
        end else begin
            ev_pipe_q <= ev_chain[EDGE_LAT-1:0];
            eb_pipe_q <= eb_chain[EDGE_LAT-1:0];
            fd_q      <= ev_in && ((edge_cnt_q + EW'(1)) == E_TOTAL);
            if (state_q == ST_IDLE) edge_cnt_q <= '0;
            else if (ev_in)         edge_cnt_q <= edge_cnt_q + EW'(1);
        end
    end

    assign win         = win_q;
    assign win_valid   = wv_q;
    assign win_border  = wb_q;
    assign edge_valid  = ev_chain[EDGE_LAT];
    assign edge_border = eb_chain[EDGE_LAT];
    assign frame_done  = fd_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Bench for sobel_window_ctrl: two instances (edge latency 1 and 3) share the
// pixel stream; a frame-level model predicts every window and edge qualifier.
module tb_sobel_window_ctrl;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [1:0]       start_w;
    logic [7:0]       s_pix;
    logic             s_valid;
    logic [1:0]       s_ready_w, win_valid_w, win_border_w, edge_valid_w;
    logic [1:0]       edge_border_w, frame_done_w, busy_w;
    logic [1:0][71:0] win_w;

    sobel_window_ctrl #(.IMG_W(W), .IMG_H(H), .EDGE_LAT(1)) u_dut_lat1 (
        .clk(clk), .rst(rst), .start(start_w[0]), .s_pix(s_pix), .s_valid(s_valid),
        .s_ready(s_ready_w[0]), .win(win_w[0]), .win_valid(win_valid_w[0]),
        .win_border(win_border_w[0]), .edge_valid(edge_valid_w[0]),
        .edge_border(edge_border_w[0]), .frame_done(frame_done_w[0]), .busy(busy_w[0])
    );

    sobel_window_ctrl #(.IMG_W(W), .IMG_H(H), .EDGE_LAT(3)) u_dut_lat3 (
        .clk(clk), .rst(rst), .start(start_w[1]), .s_pix(s_pix), .s_valid(s_valid),
        .s_ready(s_ready_w[1]), .win(win_w[1]), .win_valid(win_valid_w[1]),
        .win_border(win_border_w[1]), .edge_valid(edge_valid_w[1]),
        .edge_border(edge_border_w[1]), .frame_done(frame_done_w[1]), .busy(busy_w[1])
    );

    // scoreboard state
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int frames_exp = 0;
    logic [72:0] exp_q0[$], exp_q1[$];        // {border, window}
    logic [1:0]  exp_e_q0[$], exp_e_q1[$];    // {border, last}
    int          wv_cyc_q0[$], wv_cyc_q1[$];
    int acc_cnt[2], win_idx[2], last_acc_edge[2], last_win_cyc[2], done_cnt[2];
    logic [7:0] img [N];

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    // reference model: every centre of the frame, in raster order
    task automatic push_expected();
        for (int n = 0; n < N; n++) begin
            int r = n / W;
            int c = n % W;
            logic b = (r == 0) || (r == H - 1) || (c == 0) || (c == W - 1);
            logic [71:0] w = '0;
            if (!b) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        w = {w[63:0], img[(r - 1 + i) * W + (c - 1 + j)]};
            end
            exp_q0.push_back({b, w});
            exp_q1.push_back({b, w});
            exp_e_q0.push_back({b, (n == N - 1)});
            exp_e_q1.push_back({b, (n == N - 1)});
        end
    endtask

    task automatic mon_step(input int g);
        logic [72:0] wi;
        logic [1:0]  ei;
        int          c0;
        int          n;
        if (!busy_w[g]) begin
            acc_cnt[g] = 0;
            win_idx[g] = 0;
            if (g == 0) wv_cyc_q0.delete(); else wv_cyc_q1.delete();
        end
        if (win_valid_w[g]) begin
            n = win_idx[g];
            if (((g == 0) ? exp_q0.size() : exp_q1.size()) == 0) begin
                check("win_unexpected", 72'(win_valid_w[g]), 72'd0);
            end else begin
                wi = (g == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                check("win_border", 72'(win_border_w[g]), 72'(wi[72]));
                if (!wi[72]) check("win_contents", win_w[g], wi[71:0]);
            end
            if (n + W + 1 < N) begin
                check("win_follows_accept", 72'(cyc), 72'(last_acc_edge[g]));
                check("win_accept_index", 72'(acc_cnt[g]), 72'(n + W + 2));
            end else begin
                check("flush_win_consecutive", 72'(cyc), 72'(last_win_cyc[g] + 1));
                check("flush_after_all_accepts", 72'(acc_cnt[g]), 72'(N));
            end
            last_win_cyc[g] = cyc;
            win_idx[g]++;
            if (g == 0) wv_cyc_q0.push_back(cyc); else wv_cyc_q1.push_back(cyc);
        end
        if (edge_valid_w[g]) begin
            if (((g == 0) ? exp_e_q0.size() : exp_e_q1.size()) == 0) begin
                check("edge_unexpected", 72'(edge_valid_w[g]), 72'd0);
            end else begin
                ei = (g == 0) ? exp_e_q0.pop_front() : exp_e_q1.pop_front();
                check("edge_border", 72'(edge_border_w[g]), 72'(ei[1]));
                check("frame_done_on_last", 72'(frame_done_w[g]), 72'(ei[0]));
            end
            if (((g == 0) ? wv_cyc_q0.size() : wv_cyc_q1.size()) != 0) begin
                c0 = (g == 0) ? wv_cyc_q0.pop_front() : wv_cyc_q1.pop_front();
                check("edge_lag", 72'(cyc - c0), 72'(lat_of(g)));
            end
        end else begin
            check("frame_done_without_edge", 72'(frame_done_w[g]), 72'd0);
        end
        if (frame_done_w[g]) begin
            done_cnt[g]++;
            check("frame_window_count", 72'(win_idx[g]), 72'(N));
            check("frame_accept_count", 72'(acc_cnt[g]), 72'(N));
        end
        if (s_valid && s_ready_w[g]) begin
            acc_cnt[g]++;
            last_acc_edge[g] = cyc + 1;
        end
    endtask

    // monitor: samples on the falling edge, away from the active edge
    always @(negedge clk) begin
        cyc++;
        for (int g = 0; g < 2; g++) mon_step(g);
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 back-to-back, 1 toggled valid, 2 random valid
    task automatic run_frame(input int mode, input bit seq, input bit mid_start,
                             input bit start_at_done, input int abort_at);
        int idx, guard;
        bit v, acc;
        bit [1:0] pend;
        for (int i = 0; i < N; i++)
            img[i] = seq ? 8'(i + 1) : 8'($urandom_range(0, 255));
        push_expected();
        start_w = 2'b11;
        tick();
        start_w = 2'b00;
        idx = 0;
        guard = 0;
        while (idx < N && guard < 500 && !(abort_at > 0 && idx == abort_at)) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (guard % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            s_valid = v;
            s_pix   = img[idx];
            start_w = (mid_start && idx == 6) ? 2'b11 : 2'b00;
            acc = v && s_ready_w[0];
            tick();
            if (acc) idx++;
            guard++;
        end
        s_valid = 1'b0;
        start_w = 2'b00;
        if (abort_at > 0) begin
            rst = 1'b1;
            tick();
            exp_q0.delete();
            exp_q1.delete();
            exp_e_q0.delete();
            exp_e_q1.delete();
            check("abort_busy", 72'(busy_w), 72'd0);
            check("abort_s_ready", 72'(s_ready_w), 72'd0);
            check("abort_edge_valid", 72'(edge_valid_w), 72'd0);
            check("abort_frame_done", 72'(frame_done_w), 72'd0);
            rst = 1'b0;
            tick();
            return;
        end
        check("input_phase_accepts", 72'(idx), 72'(N));
        frames_exp++;
        pend = 2'b00;
        guard = 0;
        while ((busy_w != 2'b00 || pend != 2'b00) && guard < 200) begin
            tick();
            guard++;
            for (int g = 0; g < 2; g++) begin
                if (pend[g]) begin
                    check("start_at_done_ignored", 72'(busy_w[g]), 72'd0);
                    start_w[g] = 1'b0;
                    pend[g] = 1'b0;
                end else if (start_at_done && frame_done_w[g]) begin
                    start_w[g] = 1'b1;
                    pend[g] = 1'b1;
                end
            end
        end
        check("frame_drain_in_budget", 72'(guard < 200), 72'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no end of test, expected end of test");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int g = 0; g < 2; g++) begin
            acc_cnt[g] = 0; win_idx[g] = 0; last_acc_edge[g] = 0;
            last_win_cyc[g] = 0; done_cnt[g] = 0;
        end
        rst = 1'b1;
        start_w = 2'b00;
        s_valid = 1'b0;
        s_pix = 8'd0;
        repeat (3) tick();
        for (int g = 0; g < 2; g++) begin
            check("rst_busy", 72'(busy_w[g]), 72'd0);
            check("rst_s_ready", 72'(s_ready_w[g]), 72'd0);
            check("rst_win", win_w[g], 72'd0);
            check("rst_win_valid", 72'(win_valid_w[g]), 72'd0);
            check("rst_win_border", 72'(win_border_w[g]), 72'd0);
            check("rst_edge_valid", 72'(edge_valid_w[g]), 72'd0);
            check("rst_edge_border", 72'(edge_border_w[g]), 72'd0);
            check("rst_frame_done", 72'(frame_done_w[g]), 72'd0);
        end
        rst = 1'b0;
        tick();

        run_frame(0, 1'b1, 1'b0, 1'b0, 0);   // pixels 1..12 back-to-back
        run_frame(1, 1'b1, 1'b0, 1'b0, 0);   // toggled valid
        run_frame(0, 1'b1, 1'b0, 1'b0, 7);   // reset after 7 accepts
        run_frame(0, 1'b1, 1'b0, 1'b0, 0);   // clean frame after reset
        run_frame(2, 1'b0, 1'b1, 1'b0, 0);   // start pulsed while busy
        run_frame(0, 1'b0, 1'b0, 1'b1, 0);   // start with frame_done
        for (int f = 0; f < 4; f++)
            run_frame((f % 2 == 0) ? 0 : 2, 1'b0, 1'b0, 1'b0, 0);

        repeat (10) tick();
        check("leftover_win_lat1", 72'(exp_q0.size()), 72'd0);
        check("leftover_win_lat3", 72'(exp_q1.size()), 72'd0);
        check("leftover_edge_lat1", 72'(exp_e_q0.size()), 72'd0);
        check("leftover_edge_lat3", 72'(exp_e_q1.size()), 72'd0);
        check("frame_done_total_lat1", 72'(done_cnt[0]), 72'(frames_exp));
        check("frame_done_total_lat3", 72'(done_cnt[1]), 72'(frames_exp));
        check("idle_at_end", 72'(busy_w), 72'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
